cascade_counter_chain: RTL and testbench

CASCADE_COUNTER_CHAIN -- requirements
Module: cascade_counter_chain

---
 rtl/cascade_counter_chain_if.sv | 27 ++
 rtl/cascade_counter_chain.sv | 102 ++++++++++
 tb/tb_cascade_counter_chain.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cascade_counter_chain_if.sv
// Control and status bundle for cascade_counter_chain.
// Master drives step/down/clear/limit inputs; slave returns count, flags, carry and wrap pulse.
interface cascade_counter_chain_if #(
  parameter int STAGE_COUNT = 3,
  parameter int BIT_WIDTH   = 4
);
  logic                             step;
  logic                             down;
  logic                             clear;
  logic                             limit_load;
  logic [STAGE_COUNT*BIT_WIDTH-1:0] limit_in;
  logic [STAGE_COUNT*BIT_WIDTH-1:0] count;
  logic [STAGE_COUNT-1:0]           stage_is_zero;
  logic [STAGE_COUNT-1:0]           stage_is_max;
  logic                             carry_out;
  logic                             wrap_pulse;

  modport master (
    output step, down, clear, limit_load, limit_in,
    input  count, stage_is_zero, stage_is_max, carry_out, wrap_pulse
  );

  modport slave (
    input  step, down, clear, limit_load, limit_in,
    output count, stage_is_zero, stage_is_max, carry_out, wrap_pulse
  );
endinterface

// File: rtl/cascade_counter_chain.sv
// Up/down mixed-radix counter chain with per-stage limits; all stages update on one edge.
// carry_out is same-cycle combinational, wrap_pulse follows one cycle later; no backpressure.
module cascade_counter_chain #(
  parameter int STAGE_COUNT = 3,
  parameter int BIT_WIDTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  cascade_counter_chain_if.slave bus
);

  typedef logic [STAGE_COUNT-1:0][BIT_WIDTH-1:0] stages_t;

  stages_t                cnt_q, cnt_d;
  stages_t                lim_q, lim_d;
  stages_t                shd_q, shd_d;
  logic                   pend_q, pend_d;
  logic                   wrap_q;
  stages_t                lim_in;
  logic [STAGE_COUNT:0]   carry;
  logic [STAGE_COUNT-1:0] is_zero;
  logic [STAGE_COUNT-1:0] is_max;
  logic                   terminal;
  logic                   commit;

  assign lim_in = bus.limit_in;

  // A stage whose limit is 0 reads as both zero and max, so carry passes straight through it.
  always_comb begin
    carry    = '0;
    is_zero  = '0;
    is_max   = '0;
    carry[0] = bus.step & ~bus.clear;
    for (int i = 0; i < STAGE_COUNT; i++) begin
      is_zero[i]  = (cnt_q[i] == '0);
      is_max[i]   = (cnt_q[i] == lim_q[i]);
      carry[i+1]  = carry[i] & (bus.down ? is_zero[i] : is_max[i]);
    end
  end

  assign terminal = carry[STAGE_COUNT];
  assign commit   = terminal | bus.clear;

  // Limits only move when every stage is zero or reloading, so counts never exceed them.
  always_comb begin
    lim_d  = lim_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (commit) begin
      if (bus.limit_load) begin
        lim_d  = lim_in;
        shd_d  = lim_in;
        pend_d = 1'b0;
      end else if (pend_q) begin
        lim_d  = shd_q;
        pend_d = 1'b0;
      end
    end else if (bus.limit_load) begin
      shd_d  = lim_in;
      pend_d = 1'b1;
    end
  end

  // Down-mode wraps reload from lim_d so a terminal borrow picks up freshly committed limits.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < STAGE_COUNT; i++) begin
      if (bus.clear) begin
        cnt_d[i] = '0;
      end else if (carry[i]) begin
        if (bus.down) begin
          cnt_d[i] = is_zero[i] ? lim_d[i] : (cnt_q[i] - BIT_WIDTH'(1));
        end else begin
          cnt_d[i] = is_max[i] ? '0 : (cnt_q[i] + BIT_WIDTH'(1));
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      lim_q  <= '1;
      shd_q  <= '1;
      pend_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      wrap_q <= terminal;
    end
  end

  assign bus.count         = cnt_q;
  assign bus.stage_is_zero = is_zero;
  assign bus.stage_is_max  = is_max;
  assign bus.carry_out     = terminal;
  assign bus.wrap_pulse    = wrap_q;

endmodule

// File: tb/tb_cascade_counter_chain.sv
// Bench for cascade_counter_chain (3 stages x 4 bits): vector table, corner sequences, random vs model.
// The model treats the chain as one integer in a mixed radix of (limit+1) per stage.
module tb_cascade_counter_chain;
  localparam int N = 3;
  localparam int W = 4;

  logic clock;
  logic reset;

  cascade_counter_chain_if #(.STAGE_COUNT(N), .BIT_WIDTH(W)) bus ();

  cascade_counter_chain #(.STAGE_COUNT(N), .BIT_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Stimulus currently applied
  bit          r_i, st_i, dn_i, cl_i, ll_i;
  logic [11:0] li_i;

  // Reference model state
  int mval;
  int lim [N];
  int shd [N];
  bit pend;
  bit mwrap;

  typedef struct {
    bit          r, st, dn, cl, ll;
    logic [11:0] li;
    logic [11:0] cnt;
    logic [2:0]  z, m;
    bit          co, wr;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int total();
    int t = 1;
    for (int i = 0; i < N; i++) t = t * (lim[i] + 1);
    return t;
  endfunction

  function automatic int digit(input int i);
    int p = 1;
    for (int j = 0; j < i; j++) p = p * (lim[j] + 1);
    return (mval / p) % (lim[i] + 1);
  endfunction

  function automatic logic [11:0] exp_count();
    logic [11:0] e = '0;
    for (int i = 0; i < N; i++) e = e | (12'(digit(i)) << (W * i));
    return e;
  endfunction

  function automatic logic [2:0] exp_zero();
    logic [2:0] e = '0;
    for (int i = 0; i < N; i++) e[i] = (digit(i) == 0);
    return e;
  endfunction

  function automatic logic [2:0] exp_max();
    logic [2:0] e = '0;
    for (int i = 0; i < N; i++) e[i] = (digit(i) == lim[i]);
    return e;
  endfunction

  function automatic bit exp_co();
    if (!st_i || cl_i) return 1'b0;
    return dn_i ? (mval == 0) : (mval == total() - 1);
  endfunction

  task automatic model_step();
    bit co;
    co = exp_co();
    if (r_i) begin
      mval  = 0;
      pend  = 0;
      mwrap = 0;
      for (int i = 0; i < N; i++) begin
        lim[i] = 15;
        shd[i] = 15;
      end
    end else begin
      if (co || cl_i) begin
        if (ll_i) begin
          for (int i = 0; i < N; i++) begin
            lim[i] = int'((li_i >> (W * i)) & 12'hF);
            shd[i] = lim[i];
          end
          pend = 0;
        end else if (pend) begin
          for (int i = 0; i < N; i++) lim[i] = shd[i];
          pend = 0;
        end
      end else if (ll_i) begin
        for (int i = 0; i < N; i++) shd[i] = int'((li_i >> (W * i)) & 12'hF);
        pend = 1;
      end
      if (cl_i) mval = 0;
      else if (st_i) begin
        if (dn_i) mval = (mval == 0) ? total() - 1 : mval - 1;
        else      mval = co ? 0 : mval + 1;
      end
      mwrap = co;
    end
  endtask

  // Drive inputs and move to the sampling point (negedge) of the cycle.
  task automatic apply(input bit r, st, dn, cl, ll, input logic [11:0] li);
    r_i = r; st_i = st; dn_i = dn; cl_i = cl; ll_i = ll; li_i = li;
    reset          = r;
    bus.step       = st;
    bus.down       = dn;
    bus.clear      = cl;
    bus.limit_load = ll;
    bus.limit_in   = li;
    @(negedge clock);
  endtask

  task automatic adv();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_model();
    chk("count", 32'(bus.count), 32'(exp_count()));
    chk("carry_out", 32'(bus.carry_out), 32'(exp_co()));
    chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(mwrap));
    chk("is_zero", 32'(bus.stage_is_zero), 32'(exp_zero()));
    chk("is_max", 32'(bus.stage_is_max), 32'(exp_max()));
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 12'h000);
    adv();
  endtask

  initial begin
    tv[0]  = '{0,0,0,0,1,12'h249, 12'h000,3'b111,3'b000,0,0};
    tv[1]  = '{0,1,0,0,0,12'h000, 12'h000,3'b111,3'b000,0,0};
    tv[2]  = '{0,0,0,1,0,12'h000, 12'h001,3'b110,3'b000,0,0};
    tv[3]  = '{0,1,1,0,0,12'h000, 12'h000,3'b111,3'b000,1,0};
    tv[4]  = '{0,0,1,0,0,12'h000, 12'h249,3'b000,3'b111,0,1};
    tv[5]  = '{0,1,0,0,0,12'h000, 12'h249,3'b000,3'b111,1,0};
    tv[6]  = '{0,1,0,0,0,12'h000, 12'h000,3'b111,3'b000,0,1};
    tv[7]  = '{0,0,0,0,1,12'h111, 12'h001,3'b110,3'b000,0,0};
    tv[8]  = '{0,1,0,0,0,12'h000, 12'h001,3'b110,3'b000,0,0};
    tv[9]  = '{0,1,1,0,0,12'h000, 12'h002,3'b110,3'b000,0,0};
    tv[10] = '{0,1,0,1,0,12'h000, 12'h001,3'b110,3'b000,0,0};
    tv[11] = '{0,1,1,0,0,12'h000, 12'h000,3'b111,3'b000,1,0};
    tv[12] = '{0,0,0,0,0,12'h000, 12'h111,3'b000,3'b111,0,1};
    tv[13] = '{0,1,0,0,0,12'h000, 12'h111,3'b000,3'b111,1,0};
    tv[14] = '{1,1,0,1,1,12'h000, 12'h000,3'b111,3'b000,0,1};
    tv[15] = '{0,1,1,0,0,12'h000, 12'h000,3'b111,3'b000,1,0};
    tv[16] = '{0,0,0,0,0,12'h000, 12'hFFF,3'b000,3'b111,0,1};

    do_reset();

    // Vector table: limit shadowing, commit on clear/terminal, reset priority
    for (int k = 0; k < 17; k++) begin
      apply(tv[k].r, tv[k].st, tv[k].dn, tv[k].cl, tv[k].ll, tv[k].li);
      chk($sformatf("vec%0d count", k), 32'(bus.count), 32'(tv[k].cnt));
      chk($sformatf("vec%0d zero", k), 32'(bus.stage_is_zero), 32'(tv[k].z));
      chk($sformatf("vec%0d max", k), 32'(bus.stage_is_max), 32'(tv[k].m));
      chk($sformatf("vec%0d carry", k), 32'(bus.carry_out), 32'(tv[k].co));
      chk($sformatf("vec%0d wrap", k), 32'(bus.wrap_pulse), 32'(tv[k].wr));
      adv();
    end

    // Full up-count wrap with default limits
    do_reset();
    for (int k = 0; k < 4096; k++) begin
      apply(0, 1, 0, 0, 0, 12'h000);
      check_model();
      if (k == 4095) begin
        chk("full_wrap count", 32'(bus.count), 32'hFFF);
        chk("full_wrap carry", 32'(bus.carry_out), 32'd1);
      end
      adv();
    end
    apply(0, 0, 0, 0, 0, 12'h000);
    chk("full_wrap post count", 32'(bus.count), 32'h000);
    chk("full_wrap post wrap", 32'(bus.wrap_pulse), 32'd1);
    adv();
    apply(0, 0, 0, 0, 0, 12'h000);
    chk("full_wrap pulse width", 32'(bus.wrap_pulse), 32'd0);
    adv();

    // Limits 2:4:9 commit on the first terminal borrow, then mixed-radix up count
    do_reset();
    apply(0, 0, 0, 0, 1, 12'h249); check_model(); adv();
    apply(0, 1, 1, 0, 0, 12'h000); check_model(); adv();
    chk("commit_on_terminal count", 32'(bus.count), 32'h249);
    apply(0, 1, 0, 0, 0, 12'h000); check_model(); adv();
    for (int k = 0; k < 150; k++) begin
      apply(0, 1, 0, 0, 0, 12'h000);
      check_model();
      if (k == 9)   chk("radix 009", 32'(bus.count), 32'h009);
      if (k == 10)  chk("radix 010", 32'(bus.count), 32'h010);
      if (k == 50)  chk("radix 100", 32'(bus.count), 32'h100);
      if (k == 149) begin
        chk("radix 249", 32'(bus.count), 32'h249);
        chk("radix carry", 32'(bus.carry_out), 32'd1);
      end
      adv();
    end

    // Stage 1 limit 0: stage 0 wrap feeds stage 2 directly
    do_reset();
    apply(0, 0, 0, 1, 1, 12'hF0F); check_model(); adv();
    for (int k = 0; k < 40; k++) begin
      apply(0, 1, 0, 0, 0, 12'h000);
      check_model();
      if (k == 16) chk("zero_limit passthrough", 32'(bus.count), 32'h100);
      adv();
    end

    // Randomised traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic [11:0] li;
      li = '0;
      for (int i = 0; i < N; i++)
        li = li | (12'(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15)) << (W * i));
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0), li);
      check_model();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
